// File: rtl/cpu_sound_pkg.sv
// Shared types and constants for the main-CPU side of the sound command channel.
package cpu_sound_pkg;

    // Sequencer states of the command transmitter.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        INT    = 3'd4,
        GAP    = 3'd5,
        CLEAR  = 3'd6
    } snd_state_t;

    // Width of the CLR_AL pulse that wipes the sound-side latches.
    localparam int CLR_PULSE_CYCLES = 2;

    // Value the sound Z80 interprets as "do nothing".
    localparam logic [7:0] SOUND_CMD_NOP = 8'h00;

    // Strobe and interrupt pulses cannot be shorter than one cycle.
    function automatic int at_least_one(input int n);
        return (n < 1) ? 1 : n;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO: the head entry is visible on
// head while empty is low, and pop simply advances to the next entry.
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    // Pushes into a full FIFO and pops from an empty one are ignored.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign full  = (level == LVL_W'(DEPTH));
    assign empty = (level == '0);
    assign head  = mem[rd_ptr];

    // Storage array; contents need no reset because level gates their use.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level <= level + LVL_W'(do_push) - LVL_W'(do_pop);
        end
    end

endmodule

// File: rtl/cpu_sound_command_transmitter.sv
// Main-CPU side of the sound command channel. Queues command bytes and plays
// each one onto the sound board latch interface: DB set up, OUT0_AL strobe
// (LS175 capture on the rising edge), DB hold, INT_AL pulse (LS74 set on the
// rising edge), then a gap so the sound Z80 can read the latches.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | nothing in flight; pops the FIFO head into DB when available
// SETUP  | DB driven, waiting before the strobe falls
// STROBE | OUT0_AL low, LS175 pair transparent to DB
// HOLD   | OUT0_AL back high, DB still held for the latch hold time
// INT    | INT_AL low, requesting a sound Z80 interrupt
// GAP    | quiet time for the sound Z80 to read the latches
// CLEAR  | CLR_AL low, latches wiped, FIFO flushed
module cpu_sound_command_transmitter
    import cpu_sound_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int SETUP_CYCLES  = 2,
    parameter int STROBE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1,
    parameter int INT_CYCLES    = 4,
    parameter int GAP_CYCLES    = 64
) (
    input  logic                          CPU_CLOCK,
    input  logic                          RESET,
    input  logic [7:0]                    CMD_DATA,
    input  logic                          CMD_VALID,
    output logic                          CMD_READY,
    input  logic                          CLR_REQ,
    output logic [7:0]                    DB,
    output logic                          OUT0_AL,
    output logic                          INT_AL,
    output logic                          CLR_AL,
    output logic                          BUSY,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
    output logic                          OVERFLOW
);

    localparam int LVL_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int STROBE_N = at_least_one(STROBE_CYCLES);
    localparam int INT_N    = at_least_one(INT_CYCLES);
    localparam int MAX_N    = max_int(max_int(max_int(SETUP_CYCLES, STROBE_N),
                                              max_int(HOLD_CYCLES, INT_N)),
                                      max_int(GAP_CYCLES, CLR_PULSE_CYCLES));
    // The counter only ever holds N-1, so clog2(MAX_N) bits suffice.
    localparam int CNT_W    = (MAX_N > 1) ? $clog2(MAX_N) : 1;

    snd_state_t       state;
    snd_state_t       state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             enter;
    logic             cnt_done;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_flush;
    logic [7:0]       fifo_head;
    logic [LVL_W-1:0] fifo_level;
    logic [LVL_W-1:0] level_nx;
    logic             fifo_full;
    logic             fifo_empty;

    logic [7:0]       db_nx;
    logic             out0_nx;
    logic             int_nx;
    logic             clr_nx;
    logic             busy_nx;
    logic             ready_nx;
    logic             ovf_nx;

    // Dwell time of each timed state, expressed as the counter's load value.
    function automatic logic [CNT_W-1:0] load_for(input snd_state_t s);
        logic [CNT_W-1:0] v;
        v = '0;
        case (s)
            SETUP:   v = CNT_W'(SETUP_CYCLES - 1);
            STROBE:  v = CNT_W'(STROBE_N - 1);
            HOLD:    v = CNT_W'(HOLD_CYCLES - 1);
            INT:     v = CNT_W'(INT_N - 1);
            GAP:     v = CNT_W'(GAP_CYCLES - 1);
            CLEAR:   v = CNT_W'(CLR_PULSE_CYCLES - 1);
            default: v = '0;
        endcase
        return v;
    endfunction

    // A clear request wins over any write or pop in the same cycle.
    assign fifo_flush = CLR_REQ;
    assign fifo_push  = CMD_VALID & CMD_READY & ~fifo_full & ~CLR_REQ;
    assign fifo_pop   = (state == IDLE) & ~fifo_empty & ~CLR_REQ;
    assign level_nx   = fifo_flush ? '0
                      : fifo_level + LVL_W'(fifo_push) - LVL_W'(fifo_pop);
    assign cnt_done   = (cnt == '0);

    sync_fifo_fwft #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk       (CPU_CLOCK),
        .rst       (RESET),
        .push      (fifo_push),
        .push_data (CMD_DATA),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .head      (fifo_head),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign FIFO_LEVEL = fifo_level;

    // State register and the shared dwell down-counter.
    always_ff @(posedge CPU_CLOCK) begin
        if (RESET) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state logic; zero-length SETUP, HOLD and GAP are skipped entirely.
    always_comb begin
        state_nx = state;
        enter    = 1'b0;
        if (CLR_REQ) begin
            state_nx = CLEAR;
            enter    = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state_nx = (SETUP_CYCLES > 0) ? SETUP : STROBE;
                        enter    = 1'b1;
                    end
                end
                SETUP: begin
                    if (cnt_done) begin
                        state_nx = STROBE;
                        enter    = 1'b1;
                    end
                end
                STROBE: begin
                    if (cnt_done) begin
                        state_nx = (HOLD_CYCLES > 0) ? HOLD : INT;
                        enter    = 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt_done) begin
                        state_nx = INT;
                        enter    = 1'b1;
                    end
                end
                INT: begin
                    if (cnt_done) begin
                        state_nx = (GAP_CYCLES > 0) ? GAP : IDLE;
                        enter    = 1'b1;
                    end
                end
                GAP: begin
                    if (cnt_done) begin
                        state_nx = IDLE;
                        enter    = 1'b1;
                    end
                end
                CLEAR: begin
                    if (cnt_done) begin
                        state_nx = IDLE;
                        enter    = 1'b1;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    enter    = 1'b1;
                end
            endcase
        end
        cnt_nx = enter ? load_for(state_nx)
               : (cnt_done ? cnt : cnt - CNT_W'(1));
    end

    // Output values for the next cycle, derived from the state being entered
    // so the registered pins line up exactly with the state register.
    always_comb begin
        db_nx = DB;
        if (CLR_REQ) begin
            db_nx = SOUND_CMD_NOP;
        end else if (fifo_pop) begin
            db_nx = fifo_head;
        end
        out0_nx  = (state_nx != STROBE);
        int_nx   = (state_nx != INT);
        clr_nx   = (state_nx != CLEAR);
        busy_nx  = (state_nx != IDLE) || (level_nx != '0);
        ready_nx = (state_nx != CLEAR) && (level_nx != LVL_W'(FIFO_DEPTH));
        ovf_nx   = CLR_REQ ? 1'b0 : (OVERFLOW | (CMD_VALID & fifo_full));
    end

    // Output registers; reset parks the latch interface in its quiet state
    // with the latches held clear.
    always_ff @(posedge CPU_CLOCK) begin
        if (RESET) begin
            DB        <= SOUND_CMD_NOP;
            OUT0_AL   <= 1'b1;
            INT_AL    <= 1'b1;
            CLR_AL    <= 1'b0;
            BUSY      <= 1'b0;
            CMD_READY <= 1'b0;
            OVERFLOW  <= 1'b0;
        end else begin
            DB        <= db_nx;
            OUT0_AL   <= out0_nx;
            INT_AL    <= int_nx;
            CLR_AL    <= clr_nx;
            BUSY      <= busy_nx;
            CMD_READY <= ready_nx;
            OVERFLOW  <= ovf_nx;
        end
    end

endmodule

// File: tb/tb_cpu_sound_command_transmitter.sv
// Bench for the sound command transmitter. The directed sequence pushes the
// bytes it expects the sound latches to capture into exp_q; a monitor models
// the LS175 (capture on OUT0_AL rising) and LS74 (set on INT_AL rising) and
// pops/compares on every capture.
module tb_cpu_sound_command_transmitter;

    localparam int DEPTH = 4;

    logic       CPU_CLOCK = 1'b0;
    logic       RESET;
    logic [7:0] CMD_DATA;
    logic       CMD_VALID;
    logic       CMD_READY;
    logic       CLR_REQ;
    logic [7:0] DB;
    logic       OUT0_AL;
    logic       INT_AL;
    logic       CLR_AL;
    logic       BUSY;
    logic [2:0] FIFO_LEVEL;
    logic       OVERFLOW;

    cpu_sound_command_transmitter #(
        .FIFO_DEPTH    (DEPTH),
        .SETUP_CYCLES  (2),
        .STROBE_CYCLES (2),
        .HOLD_CYCLES   (1),
        .INT_CYCLES    (4),
        .GAP_CYCLES    (64)
    ) dut (
        .CPU_CLOCK  (CPU_CLOCK),
        .RESET      (RESET),
        .CMD_DATA   (CMD_DATA),
        .CMD_VALID  (CMD_VALID),
        .CMD_READY  (CMD_READY),
        .CLR_REQ    (CLR_REQ),
        .DB         (DB),
        .OUT0_AL    (OUT0_AL),
        .INT_AL     (INT_AL),
        .CLR_AL     (CLR_AL),
        .BUSY       (BUSY),
        .FIFO_LEVEL (FIFO_LEVEL),
        .OVERFLOW   (OVERFLOW)
    );

    always #5 CPU_CLOCK = ~CPU_CLOCK;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always @(posedge CPU_CLOCK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic violation(input string name, input logic [31:0] act, input logic [31:0] exp);
        miscompares++;
        $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Inputs are driven, and outputs read, 1 time unit after the rising edge.
    task automatic next_cycle();
        @(posedge CPU_CLOCK);
        #1;
    endtask

    // ---------------- scoreboard / latch models ----------------
    logic [7:0] exp_q[$];
    int         fall_log[$];
    int         captures      = 0;
    int         int_sets      = 0;
    int         out0_fall_cyc = 0;
    int         out0_rise_cyc = 0;
    int         int_fall_cyc  = 0;
    int         int_rise_cyc  = 0;
    logic       prev_out0     = 1'b1;
    logic       prev_int      = 1'b1;
    logic [7:0] prev_db       = 8'h00;

    // Monitor: samples on the falling edge, away from the DUT's active edge.
    always @(negedge CPU_CLOCK) begin
        if (!OUT0_AL && !INT_AL)
            violation("strobe_int_overlap", {OUT0_AL, INT_AL}, 2'b11);
        if (CMD_READY && FIFO_LEVEL == 3'(DEPTH))
            violation("ready_while_full", CMD_READY, 0);
        if (!RESET) begin
            if (!prev_out0 && DB !== prev_db)
                violation("db_moved_during_strobe_or_hold", DB, prev_db);
            if (prev_out0 && !OUT0_AL) begin
                out0_fall_cyc = cyc;
                fall_log.push_back(cyc);
            end
            if (!prev_out0 && OUT0_AL) begin
                out0_rise_cyc = cyc;
                captures++;
                if (exp_q.size() == 0)
                    violation("unexpected_capture", DB, 0);
                else
                    check("capture_db", DB, exp_q.pop_front());
            end
            if (prev_int && !INT_AL) int_fall_cyc = cyc;
            if (!prev_int && INT_AL) begin
                int_rise_cyc = cyc;
                int_sets++;
            end
        end
        prev_out0 = OUT0_AL;
        prev_int  = INT_AL;
        prev_db   = DB;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int c;
        int cap0;
        int set0;
        int n;
        logic [2:0] max_lvl;

        RESET     = 1'b1;
        CLR_REQ   = 1'b0;
        CMD_VALID = 1'b0;
        CMD_DATA  = 8'h00;

        // Reset values.
        repeat (3) next_cycle();
        check("rst_out0", OUT0_AL, 1);
        check("rst_int", INT_AL, 1);
        check("rst_clr", CLR_AL, 0);
        check("rst_db", DB, 8'h00);
        check("rst_ready", CMD_READY, 0);
        check("rst_level", FIFO_LEVEL, 0);
        check("rst_ovf", OVERFLOW, 0);
        check("rst_busy", BUSY, 0);
        RESET = 1'b0;
        next_cycle();
        check("rel_clr", CLR_AL, 1);
        check("rel_ready", CMD_READY, 1);
        repeat (2) next_cycle();

        // Test 1: single command 0xA5, full waveform against hand-derived offsets.
        cap0 = captures;
        set0 = int_sets;
        next_cycle();
        c = cyc;
        CMD_VALID = 1'b1;
        CMD_DATA  = 8'hA5;
        exp_q.push_back(8'hA5);
        for (int k = 1; k <= 76; k++) begin
            next_cycle();
            if (k == 1) CMD_VALID = 1'b0;
            check("t1_out0", OUT0_AL, (k == 4 || k == 5) ? 1'b0 : 1'b1);
            check("t1_int", INT_AL, (k >= 7 && k <= 10) ? 1'b0 : 1'b1);
            check("t1_busy", BUSY, (k <= 74) ? 1'b1 : 1'b0);
            check("t1_db", DB, (k >= 2) ? 8'hA5 : 8'h00);
        end
        check("t1_fall_latency", out0_fall_cyc - c, 4);
        check("t1_strobe_width", out0_rise_cyc - out0_fall_cyc, 2);
        check("t1_int_width", int_rise_cyc - int_fall_cyc, 4);
        check("t1_int_after_hold", int_fall_cyc - out0_rise_cyc, 1);
        check("t1_captures", captures - cap0, 1);
        check("t1_ls74_sets", int_sets - set0, 1);

        // Test 2: four back-to-back writes, 74-cycle strobe period.
        cap0 = captures;
        max_lvl = '0;
        fall_log.delete();
        next_cycle();
        c = cyc;
        CMD_VALID = 1'b1;
        CMD_DATA  = 8'h01;
        exp_q.push_back(8'h01);
        for (int d = 2; d <= 4; d++) begin
            next_cycle();
            if (FIFO_LEVEL > max_lvl) max_lvl = FIFO_LEVEL;
            check("t2_ready", CMD_READY, 1);
            CMD_DATA = 8'(d);
            exp_q.push_back(8'(d));
        end
        next_cycle();
        CMD_VALID = 1'b0;
        n = 0;
        while (BUSY && n < 400) begin
            if (FIFO_LEVEL > max_lvl) max_lvl = FIFO_LEVEL;
            next_cycle();
            n++;
        end
        check("t2_drain", BUSY, 0);
        check("t2_peak_level", max_lvl, 3);
        check("t2_captures", captures - cap0, 4);
        check("t2_strobe_count", fall_log.size(), 4);
        for (int i = 0; i < fall_log.size() && i < 4; i++)
            check("t2_strobe_time", fall_log[i] - c, 4 + 74 * i);
        check("t2_ovf", OVERFLOW, 0);

        // Test 3: six writes into a depth-4 FIFO; the sixth is dropped.
        cap0 = captures;
        next_cycle();
        c = cyc;
        CMD_VALID = 1'b1;
        CMD_DATA  = 8'h10;
        exp_q.push_back(8'h10);
        for (int d = 1; d <= 5; d++) begin
            next_cycle();
            CMD_DATA = 8'h10 + 8'(d);
            if (d <= 4) exp_q.push_back(8'h10 + 8'(d));
            check("t3_ready", CMD_READY, (d <= 4) ? 1'b1 : 1'b0);
        end
        check("t3_level_full", FIFO_LEVEL, 4);
        next_cycle();
        CMD_VALID = 1'b0;
        check("t3_ovf_set", OVERFLOW, 1);
        n = 0;
        while (BUSY && n < 500) begin
            next_cycle();
            n++;
        end
        check("t3_drain", BUSY, 0);
        check("t3_captures", captures - cap0, 5);
        check("t3_db_keeps_last", DB, 8'h14);
        check("t3_ovf_sticky", OVERFLOW, 1);

        // Test 4: CLR_REQ during INT of 0x7E with 0x11 queued.
        cap0 = captures;
        set0 = int_sets;
        next_cycle();
        c = cyc;
        CMD_VALID = 1'b1;
        CMD_DATA  = 8'h7E;
        exp_q.push_back(8'h7E);
        next_cycle();
        CMD_DATA = 8'h11;
        next_cycle();
        CMD_VALID = 1'b0;
        repeat (6) next_cycle();
        check("t4_in_int", INT_AL, 0);
        check("t4_level_queued", FIFO_LEVEL, 1);
        check("t4_ovf_before", OVERFLOW, 1);
        CLR_REQ   = 1'b1;
        CMD_VALID = 1'b1;
        CMD_DATA  = 8'h99;
        next_cycle();
        CLR_REQ   = 1'b0;
        CMD_VALID = 1'b0;
        check("t4_clr_low1", CLR_AL, 0);
        check("t4_int_high", INT_AL, 1);
        check("t4_out0_high", OUT0_AL, 1);
        check("t4_db_nop", DB, 8'h00);
        check("t4_level_flushed", FIFO_LEVEL, 0);
        check("t4_ovf_cleared", OVERFLOW, 0);
        check("t4_ready_clear", CMD_READY, 0);
        next_cycle();
        check("t4_clr_low2", CLR_AL, 0);
        check("t4_ready_clear2", CMD_READY, 0);
        next_cycle();
        check("t4_clr_released", CLR_AL, 1);
        check("t4_ready_back", CMD_READY, 1);
        check("t4_idle", BUSY, 0);
        repeat (150) next_cycle();
        check("t4_captures", captures - cap0, 1);
        check("t4_ls74_sets", int_sets - set0, 1);
        check("t4_db_stays_nop", DB, 8'h00);
        check("t4_level_empty", FIFO_LEVEL, 0);

        // Test 5: RESET asserted during STROBE of 0x5A.
        cap0 = captures;
        set0 = int_sets;
        next_cycle();
        c = cyc;
        CMD_VALID = 1'b1;
        CMD_DATA  = 8'h5A;
        next_cycle();
        CMD_VALID = 1'b0;
        repeat (3) next_cycle();
        check("t5_in_strobe", OUT0_AL, 0);
        RESET = 1'b1;
        next_cycle();
        check("t5_out0", OUT0_AL, 1);
        check("t5_int", INT_AL, 1);
        check("t5_clr", CLR_AL, 0);
        check("t5_db", DB, 8'h00);
        check("t5_ready", CMD_READY, 0);
        repeat (2) next_cycle();
        RESET = 1'b0;
        next_cycle();
        check("t5_clr_rel", CLR_AL, 1);
        repeat (150) next_cycle();
        check("t5_no_capture", captures - cap0, 0);
        check("t5_no_ls74", int_sets - set0, 0);
        check("t5_level", FIFO_LEVEL, 0);
        check("t5_idle", BUSY, 0);

        check("pending_expected", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cpu_sound_command_transmitter.md
Name: cpu_sound_command_transmitter

Overview:
Main-CPU-side sender of the sound command channel. It accepts command bytes from the main CPU write path into a small FIFO. For each byte it sequences the sound board's latch interface: DB bus, an OUT0_AL strobe (the LS175 pair captures on the rising edge), then an INT_AL pulse (the sound-side LS74 sets on the rising edge and interrupts the sound Z80). A programmable gap between commands gives the sound Z80 time to read the latches over DIN.

Parameters:
FIFO_DEPTH, 4, command FIFO entries (power of two, >=2)
SETUP_CYCLES, 2, cycles DB is stable before OUT0_AL falls
STROBE_CYCLES, 2, OUT0_AL low width
HOLD_CYCLES, 1, cycles DB is held after OUT0_AL rises
INT_CYCLES, 4, INT_AL low width
GAP_CYCLES, 64, idle cycles after INT_AL rises, before the next command

Ports:
CPU_CLOCK  in  1  sole clock; all logic on the rising edge
RESET  in  1  synchronous, active-high reset
CMD_DATA  in  8  command byte from the main CPU
CMD_VALID  in  1  write request; accepted when CMD_VALID & CMD_READY
CMD_READY  out  1  FIFO not full
CLR_REQ  in  1  single-cycle request to clear the sound latches and flush
DB  out  8  data to the sound latches (DB7..DB0)
OUT0_AL  out  1  latch strobe, active low
INT_AL  out  1  sound interrupt request, active low
CLR_AL  out  1  latch clear, active low
BUSY  out  1  FSM not in IDLE, or FIFO not empty
FIFO_LEVEL  out  $clog2(FIFO_DEPTH)+1  current occupancy
OVERFLOW  out  1  sticky: a write was attempted while full; cleared by RESET or CLR_REQ

Behaviour:
- All outputs are registered. Reset values: DB=8'h00, OUT0_AL=1, INT_AL=1, CLR_AL=0 while RESET=1, CLR_AL=1 from the first cycle after RESET is released. CMD_READY=0 during reset. FIFO empty, OVERFLOW=0, FSM=IDLE.
- FIFO is first-word-fall-through. A push and a pop in the same cycle are legal when non-empty; level is unchanged.
- Writing while full drops the byte and sets OVERFLOW.
- FSM states and transitions:
  - IDLE: if the FIFO is non-empty, pop the head into the DB register and enter SETUP.
  - SETUP (SETUP_CYCLES) -> STROBE
  - STROBE: OUT0_AL=0 for STROBE_CYCLES -> HOLD
  - HOLD: OUT0_AL=1, DB held for HOLD_CYCLES -> INT
  - INT: INT_AL=0 for INT_CYCLES -> GAP
  - GAP (GAP_CYCLES) -> IDLE
- A parameter value of 0 skips that state, except STROBE_CYCLES and INT_CYCLES, which have a minimum of 1.
- DB keeps its last value after a command completes; it changes only on a pop or a clear.
- Timing: latency from the accepting CMD_VALID cycle (FIFO empty, IDLE) to OUT0_AL falling is 2+SETUP_CYCLES cycles (1 cycle to enqueue, 1 to pop). Command period = 1+SETUP+STROBE+HOLD+INT+GAP cycles (1 for IDLE), i.e. 74 with the defaults.
- A single down-counter, wide enough for the maximum parameter value, is shared by all timed states. It is loaded with N-1 on state entry, and the state exits when it reaches 0.
- CLR_REQ has priority over everything except RESET:
  - in the next cycle CLR_AL=0 for exactly 2 cycles;
  - FIFO flushed, OVERFLOW cleared, DB=8'h00, OUT0_AL=1, INT_AL=1;
  - FSM enters CLEAR, then IDLE.
  - CMD_READY=0 while in CLEAR. A CMD_VALID in the same cycle as CLR_REQ is discarded.
- An INT_AL pulse that is aborted mid-pulse still produces a rising edge. This is accepted: the sound side reads the cleared latches (0x00 = no-op command).
- RESET mid-operation: in the next cycle all outputs go to their reset values with no further strobe.
- OUT0_AL and INT_AL are never low in the same cycle. DB never changes while OUT0_AL=0 or during HOLD.

Decomposition:
- Package cpu_sound_pkg holds:
  - typedef enum of the FSM states: IDLE, SETUP, STROBE, HOLD, INT, GAP, CLEAR;
  - localparams CLR_PULSE_CYCLES=2 and SOUND_CMD_NOP=8'h00.
- One sub-module, sync_fifo_fwft (parameters WIDTH, DEPTH), provides push/pop/flush, level, full and empty. The FSM and counter live in the top.

Test Plan:
- Reset, then a single write of 8'hA5:
  - DB=A5 two cycles before OUT0_AL falls;
  - OUT0_AL low 2 cycles; DB held 1 cycle after it rises;
  - INT_AL low 4 cycles; next command no earlier than 64 cycles after INT_AL rises.
  - A bench LS175 model captures A5 and an LS74 model sets exactly once.
- Back-to-back writes 8'h01, 8'h02, 8'h03, 8'h04 in consecutive cycles: all accepted, FIFO_LEVEL peaks at 3 (first byte popped at once), strobes occur in order with a 74-cycle period, OVERFLOW=0.
- Six writes in consecutive cycles with DEPTH=4: the fifth or sixth is rejected while CMD_READY=0, OVERFLOW=1, exactly 5 strobes are emitted, and dropped bytes never appear on DB.
- CLR_REQ during the INT state of 8'h7E with 8'h11 queued: CLR_AL low exactly 2 cycles, INT_AL high in the next cycle, DB=00, FIFO_LEVEL=0, no strobe for 8'h11, OVERFLOW cleared.
- RESET asserted during STROBE: in the next cycle OUT0_AL=1, INT_AL=1, CLR_AL=0, DB=00, and no capture occurs after reset is released.
- Assertions throughout: OUT0_AL and INT_AL never both low; DB stable while OUT0_AL=0; CMD_READY=0 whenever FIFO_LEVEL=FIFO_DEPTH.
